// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector with valid/ready bit input, overlapping
// match detection, modulo match counter and 7-segment status display.
module seq_detect_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_MOD     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [3:0]         len_in,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  input  logic               clr_cnt,
  output logic               match,
  output logic [3:0]         hit_cnt,
  output logic               cfg_err,
  output logic [1:0]         state_o,
  output logic [7:0]         seg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HIT  = 2'd3
  } state_t;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0] MAX_LEN_V = 4'(MAX_LEN);
  localparam logic [3:0] CNT_LAST  = 4'(CNT_MOD - 1);

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat, hist, hist_new, mask;
  logic [3:0]         len, seen, seen_new;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               len_ok, accept, hit_now;

  assign len_ok    = (len_in != 4'd0) && (len_in <= MAX_LEN_V);
  assign bit_ready = (state == RUN);
  assign accept    = bit_ready && bit_valid && !load_req;
  assign hist_new  = {hist[MAX_LEN-2:0], bit_in};
  assign seen_new  = (seen == MAX_LEN_V) ? seen : seen + 4'd1;
  assign state_o   = state;

  // Only the low len bits of the shift history take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (4'(i) < len);
    end
  end

  assign hit_now = (seen_new >= len) && ((hist_new & mask) == (pat & mask));

  always_comb begin
    state_n = state;
    if (load_req) begin
      state_n = len_ok ? LOAD : IDLE;
    end else begin
      case (state)
        IDLE:    state_n = IDLE;
        LOAD:    state_n = RUN;
        RUN:     if (accept && hit_now) state_n = HIT;
        HIT:     if (hold_cnt == HOLD_LAST) state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat      <= '0;
      len      <= 4'd0;
      hist     <= '0;
      seen     <= 4'd0;
      match    <= 1'b0;
      cfg_err  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      match    <= 1'b0;
      hold_cnt <= (state == HIT) ? hold_cnt + HOLD_W'(1) : '0;
      if (load_req) begin
        // An invalid length throws away the previous pattern as well.
        cfg_err <= !len_ok;
        pat     <= len_ok ? pat_in : '0;
        len     <= len_ok ? len_in : 4'd0;
        hist    <= '0;
        seen    <= 4'd0;
      end else if (state == LOAD) begin
        hist <= '0;
        seen <= 4'd0;
      end else if (accept) begin
        hist  <= hist_new;
        seen  <= seen_new;
        match <= hit_now;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= 4'd0;
    end else if (clr_cnt) begin
      hit_cnt <= 4'd0;
    end else if (accept && hit_now) begin
      hit_cnt <= (hit_cnt == CNT_LAST) ? 4'd0 : hit_cnt + 4'd1;
    end
  end

  logic [6:0] digit;

  always_comb begin
    case (hit_cnt)
      4'd0:    digit = 7'h3F;
      4'd1:    digit = 7'h06;
      4'd2:    digit = 7'h5B;
      4'd3:    digit = 7'h4F;
      4'd4:    digit = 7'h66;
      4'd5:    digit = 7'h6D;
      4'd6:    digit = 7'h7D;
      4'd7:    digit = 7'h07;
      4'd8:    digit = 7'h7F;
      4'd9:    digit = 7'h6F;
      default: digit = 7'h00;
    endcase
  end

  always_comb begin
    if (cfg_err) begin
      seg = 8'h79;
    end else if (state == IDLE) begin
      seg = 8'h40;
    end else begin
      seg = {(state == HIT), digit};
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl: basic and overlapping
// matches, length boundaries, counter wrap, config errors, clear and reset.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_req = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic [3:0] len_in = 4'd0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_ready;
  logic       clr_cnt = 1'b0;
  logic       match;
  logic [3:0] hit_cnt;
  logic       cfg_err;
  logic [1:0] state_o;
  logic [7:0] seg;

  int checks = 0;
  int failures = 0;

  seq_detect_ctrl #(.MAX_LEN(8), .HOLD_CYCLES(4), .CNT_MOD(10)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .pat_in(pat_in), .len_in(len_in),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready), .clr_cnt(clr_cnt),
    .match(match), .hit_cnt(hit_cnt), .cfg_err(cfg_err), .state_o(state_o), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern(input logic [7:0] p, input logic [3:0] l);
    load_req = 1'b1;
    pat_in   = p;
    len_in   = l;
    tick();
    load_req = 1'b0;
  endtask

  // Waits (bounded) for bit_ready, then offers one bit; m is match after the accepting edge.
  task automatic send_bit(input logic b, output logic m);
    int waited = 0;
    while (!bit_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!bit_ready) begin
      failures++;
      checks++;
      $display("[TB] FAIL ready_timeout got bit_ready=%0b exp=1", bit_ready);
    end
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    m = match;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if (state_o !== 2'd0) begin failures++; $display("[TB] FAIL rst_state got=%0d exp=0", state_o); end
    checks++;
    if (seg !== 8'h40) begin failures++; $display("[TB] FAIL rst_seg got=%h exp=40", seg); end
    checks++;
    if ({match, cfg_err, bit_ready, hit_cnt} !== 7'd0) begin
      failures++;
      $display("[TB] FAIL rst_outputs got m=%b e=%b r=%b c=%0d exp all 0", match, cfg_err, bit_ready, hit_cnt);
    end
    checks++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic m;
    logic [2:0] bits = 3'b011;
    load_pattern(8'h03, 4'd3);
    if (state_o !== 2'd1) begin failures++; $display("[TB] FAIL t1_load_state got=%0d exp=1", state_o); end
    checks++;
    for (int i = 2; i >= 0; i--) begin
      send_bit(bits[i], m);
      if (m !== (i == 0)) begin failures++; $display("[TB] FAIL t1_match bit%0d got=%b exp=%b", 2 - i, m, (i == 0)); end
      checks++;
    end
    if (hit_cnt !== 4'd1) begin failures++; $display("[TB] FAIL t1_cnt got=%0d exp=1", hit_cnt); end
    checks++;
    for (int c = 0; c < 4; c++) begin
      if (seg !== 8'h86 || bit_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL t1_hit_seg cyc%0d got seg=%h r=%b exp seg=86 r=0", c, seg, bit_ready);
      end
      checks++;
      if (c > 0 && match !== 1'b0) begin failures++; $display("[TB] FAIL t1_pulse cyc%0d got=%b exp=0", c, match); end
      if (c > 0) checks++;
      tick();
    end
    if (seg !== 8'h06 || state_o !== 2'd2) begin
      failures++;
      $display("[TB] FAIL t1_after_hit got seg=%h st=%0d exp seg=06 st=2", seg, state_o);
    end
    checks++;
  endtask

  task automatic test_overlap();
    logic m;
    int hits = 0;
    logic [4:0] bits = 5'b10101;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    if (hit_cnt !== 4'd0) begin failures++; $display("[TB] FAIL t2_clr got=%0d exp=0", hit_cnt); end
    checks++;
    load_pattern(8'h05, 4'd3);
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i], m);
      if (m === 1'b1) begin
        hits++;
        // Bits offered during HIT must be dropped; accepting them would break the next match.
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        for (int c = 0; c < 3; c++) begin
          if (bit_ready !== 1'b0) begin failures++; $display("[TB] FAIL t2_hit_ready got=%b exp=0", bit_ready); end
          checks++;
          tick();
        end
        bit_valid = 1'b0;
      end
    end
    if (hits != 2) begin failures++; $display("[TB] FAIL t2_pulses got=%0d exp=2", hits); end
    checks++;
    if (hit_cnt !== 4'd2) begin failures++; $display("[TB] FAIL t2_cnt got=%0d exp=2", hit_cnt); end
    checks++;
  endtask

  task automatic test_len_seen();
    logic m;
    load_pattern(8'h00, 4'd4);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0, m);
      if (m !== (i == 3)) begin failures++; $display("[TB] FAIL t3_match bit%0d got=%b exp=%b", i, m, (i == 3)); end
      checks++;
    end
    if (hit_cnt !== 4'd3) begin failures++; $display("[TB] FAIL t3_cnt got=%0d exp=3", hit_cnt); end
    checks++;
  endtask

  task automatic test_wrap();
    logic m;
    int waited = 0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    load_pattern(8'h01, 4'd1);
    for (int i = 1; i <= 10; i++) begin
      send_bit(1'b1, m);
      if (m !== 1'b1 || hit_cnt !== 4'(i % 10)) begin
        failures++;
        $display("[TB] FAIL t4_count hit%0d got m=%b c=%0d exp m=1 c=%0d", i, m, hit_cnt, i % 10);
      end
      checks++;
    end
    if (seg !== 8'hBF) begin failures++; $display("[TB] FAIL t4_hit_seg got=%h exp=bf", seg); end
    checks++;
    while (!bit_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (seg !== 8'h3F || waited != 4) begin
      failures++;
      $display("[TB] FAIL t4_after_hit got seg=%h hold=%0d exp seg=3f hold=4", seg, waited);
    end
    checks++;
  endtask

  task automatic test_cfg_err();
    logic m;
    logic [7:0] bits = 8'hA5;
    load_pattern(8'h0F, 4'd0);
    if (cfg_err !== 1'b1 || state_o !== 2'd0 || seg !== 8'h79 || bit_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t5_len0 got e=%b st=%0d seg=%h r=%b exp e=1 st=0 seg=79 r=0", cfg_err, state_o, seg, bit_ready);
    end
    checks++;
    load_pattern(8'h0F, 4'd9);
    if (cfg_err !== 1'b1 || state_o !== 2'd0) begin
      failures++;
      $display("[TB] FAIL t5_len9 got e=%b st=%0d exp e=1 st=0", cfg_err, state_o);
    end
    checks++;
    load_pattern(8'hA5, 4'd8);
    if (cfg_err !== 1'b0 || state_o !== 2'd1 || seg !== 8'h3F) begin
      failures++;
      $display("[TB] FAIL t5_reload got e=%b st=%0d seg=%h exp e=0 st=1 seg=3f", cfg_err, state_o, seg);
    end
    checks++;
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i], m);
      if (m !== (i == 0)) begin failures++; $display("[TB] FAIL t5_len8 bit%0d got=%b exp=%b", 7 - i, m, (i == 0)); end
      checks++;
    end
    if (hit_cnt !== 4'd1) begin failures++; $display("[TB] FAIL t5_cnt got=%0d exp=1", hit_cnt); end
    checks++;
  endtask

  task automatic test_clr_and_reset();
    logic m;
    int waited = 0;
    load_pattern(8'h01, 4'd1);
    tick();
    clr_cnt = 1'b1;
    send_bit(1'b1, m);
    clr_cnt = 1'b0;
    if (m !== 1'b1 || hit_cnt !== 4'd0) begin
      failures++;
      $display("[TB] FAIL t6_clr_wins got m=%b c=%0d exp m=1 c=0", m, hit_cnt);
    end
    checks++;
    send_bit(1'b1, m);
    if (m !== 1'b1 || hit_cnt !== 4'd1 || state_o !== 2'd3) begin
      failures++;
      $display("[TB] FAIL t6_pre_rst got m=%b c=%0d st=%0d exp m=1 c=1 st=3", m, hit_cnt, state_o);
    end
    checks++;
    rst = 1'b1;
    #1;
    if (seg !== 8'h40 || state_o !== 2'd0 || {match, cfg_err, bit_ready, hit_cnt} !== 7'd0) begin
      failures++;
      $display("[TB] FAIL t6_async_rst got seg=%h st=%0d m=%b e=%b r=%b c=%0d exp seg=40 rest 0",
               seg, state_o, match, cfg_err, bit_ready, hit_cnt);
    end
    checks++;
    tick();
    rst = 1'b0;
    tick();
    waited = 0;
    if (waited != 0) ;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_len_seen();
    test_wrap();
    test_cfg_err();
    test_clr_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
